// File: rtl/hamming_pkg.sv
// Shared types and constants for the Hamming(12,8) shared-decoder path.
package hamming_pkg;

    typedef enum logic [1:0] {IDLE, DEC, OUT} state_t;

    localparam int unsigned CODE_W = 12;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned SYN_W  = 4;

    // Codeword positions that carry data, in output order out_data[1..8]
    localparam int unsigned DATA_POS [DATA_W] = '{3, 5, 6, 7, 9, 10, 11, 12};

    localparam logic [SYN_W-1:0] MAX_SYN = 4'd12;

endpackage

// File: rtl/hamming12_core.sv
// Combinational Hamming(12,8) single-error-correcting decoder core.
module hamming12_core
    import hamming_pkg::*;
(
    input  logic [1:CODE_W]   code,
    output logic [1:DATA_W]   data,
    output logic [SYN_W-1:0]  syndrome,
    output logic              corrected,
    output logic              bad
);

    always_comb begin
        // XOR of the indices of all set positions equals {P8,P4,P2,P1}
        syndrome = '0;
        for (int unsigned n = 1; n <= CODE_W; n++) begin
            if (code[n]) syndrome = syndrome ^ SYN_W'(n);
        end

        bad       = (syndrome > MAX_SYN);
        corrected = (syndrome != '0) && !bad;

        data = '0;
        for (int unsigned k = 0; k < DATA_W; k++) begin
            data[k+1] = code[DATA_POS[k]]
                      ^ (corrected && (syndrome == SYN_W'(DATA_POS[k])));
        end
    end

endmodule

// File: rtl/hamming_dec_arb.sv
// Two-requester round-robin front end sharing one hamming12_core.
// Optional corrected-error counter enabled by defining HAMDEC_ERRCNT_EN.
module hamming_dec_arb
    import hamming_pkg::*;
#(
    parameter int unsigned NREQ = 2
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [1:CODE_W]   req0_code,
    input  logic [1:CODE_W]   req1_code,
    output logic [NREQ-1:0]   req_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [1:DATA_W]   out_data,
    output logic              out_src,
    output logic [SYN_W-1:0]  out_syndrome,
    output logic              out_corrected,
    output logic              out_bad
`ifdef HAMDEC_ERRCNT_EN
    ,
    input  logic              err_clr,
    output logic [15:0]       err_count
`endif
);

    state_t           state;
    logic [1:CODE_W]  code_q;
    logic             src_q;
    logic             last_grant;
    logic             grant;
    logic             take;

    logic [1:DATA_W]  dec_data;
    logic [SYN_W-1:0] dec_syndrome;
    logic             dec_corrected;
    logic             dec_bad;

    hamming12_core u_core (
        .code      (code_q),
        .data      (dec_data),
        .syndrome  (dec_syndrome),
        .corrected (dec_corrected),
        .bad       (dec_bad)
    );

    always_comb begin
        case (req_valid)
            2'b01:   grant = 1'b0;
            2'b10:   grant = 1'b1;
            2'b11:   grant = ~last_grant;
            default: grant = 1'b0;
        endcase
        req_ready = '0;
        if (state == IDLE && req_valid != '0) req_ready[grant] = 1'b1;
    end

    assign take = |(req_valid & req_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            code_q        <= '0;
            src_q         <= 1'b0;
            last_grant    <= 1'b1;
            out_valid     <= 1'b0;
            out_data      <= '0;
            out_src       <= 1'b0;
            out_syndrome  <= '0;
            out_corrected <= 1'b0;
            out_bad       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (take) begin
                        code_q     <= grant ? req1_code : req0_code;
                        src_q      <= grant;
                        last_grant <= grant;
                        state      <= DEC;
                    end
                end
                DEC: begin
                    out_data      <= dec_data;
                    out_syndrome  <= dec_syndrome;
                    out_corrected <= dec_corrected;
                    out_bad       <= dec_bad;
                    out_src       <= src_q;
                    out_valid     <= 1'b1;
                    state         <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef HAMDEC_ERRCNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count <= '0;
        end else if (err_clr) begin
            err_count <= '0;
        end else if (state == OUT && out_valid && out_ready && out_corrected
                     && err_count != '1) begin
            err_count <= err_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hamming_dec_arb.sv
// Directed self-checking bench for hamming_dec_arb.
module tb_hamming_dec_arb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req_valid = '0;
    logic [1:12] req0_code = '0;
    logic [1:12] req1_code = '0;
    logic [1:0]  req_ready;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [1:8]  out_data;
    logic        out_src;
    logic [3:0]  out_syndrome;
    logic        out_corrected;
    logic        out_bad;
`ifdef HAMDEC_ERRCNT_EN
    logic        err_clr = 1'b0;
    logic [15:0] err_count;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    // Literal bit order is position 1 (leftmost) .. position 12
    localparam logic [1:12] CW_A5   = 12'b111001000101; // clean encoding of A5
    localparam logic [1:12] CW_E6   = 12'b111000000101; // A5, position 6 flipped
    localparam logic [1:12] CW_E8   = 12'b111001010101; // A5, parity position 8 flipped
    localparam logic [1:12] CW_E12  = 12'b111001000100; // A5, position 12 flipped
    localparam logic [1:12] CW_S13  = 12'b011001000100; // positions 1,12 flipped
    localparam logic [1:12] CW_S14  = 12'b101001000100; // positions 2,12 flipped
    localparam logic [1:12] CW_LIT  = 12'b011100101010; // clean, data positions give 9A

    hamming_dec_arb #(.NREQ(2)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req0_code     (req0_code),
        .req1_code     (req1_code),
        .req_ready     (req_ready),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_src       (out_src),
        .out_syndrome  (out_syndrome),
        .out_corrected (out_corrected),
        .out_bad       (out_bad)
`ifdef HAMDEC_ERRCNT_EN
        ,
        .err_clr       (err_clr),
        .err_count     (err_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, ".ready"},  32'(req_ready),     32'h0);
        check({tag, ".valid"},  32'(out_valid),     32'h0);
        check({tag, ".data"},   32'(out_data),      32'h0);
        check({tag, ".src"},    32'(out_src),       32'h0);
        check({tag, ".syn"},    32'(out_syndrome),  32'h0);
        check({tag, ".corr"},   32'(out_corrected), 32'h0);
        check({tag, ".bad"},    32'(out_bad),       32'h0);
    endtask

    // One transaction from requester r with out_ready high; checks latency and result.
    task automatic send(input int r, input logic [1:12] code, input string tag,
                        input logic [7:0] exp_data, input logic [3:0] exp_syn,
                        input logic exp_corr, input logic exp_bad);
        int n;
        @(negedge clk);
        if (r == 0) req0_code = code; else req1_code = code;
        req_valid    = '0;
        req_valid[r] = 1'b1;
        out_ready    = 1'b1;
        #1;
        n = 0;
        while (req_ready[r] !== 1'b1 && n < 20) begin
            @(negedge clk); #1; n++;
        end
        check({tag, ".grant"}, 32'(req_ready), (r == 0) ? 32'h1 : 32'h2);
        @(negedge clk);
        req_valid = '0;
        #1;
        check({tag, ".dec_valid"}, 32'(out_valid), 32'h0);
        @(negedge clk); #1;
        check({tag, ".valid"}, 32'(out_valid),     32'h1);
        check({tag, ".data"},  32'(out_data),      32'(exp_data));
        check({tag, ".syn"},   32'(out_syndrome),  32'(exp_syn));
        check({tag, ".corr"},  32'(out_corrected), 32'(exp_corr));
        check({tag, ".bad"},   32'(out_bad),       32'(exp_bad));
        check({tag, ".src"},   32'(out_src),       32'(r));
        @(negedge clk); #1;
        check({tag, ".drain"}, 32'(out_valid), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1);
    end

    initial begin
        int n;

        // Reset values
        repeat (2) @(negedge clk);
        #1;
        check_reset_vals("reset");
        @(negedge clk);
        rst = 1'b0;

        // Round robin: both valid held; first contention goes to requester 0
        @(negedge clk);
        req0_code = CW_A5;
        req1_code = CW_E6;
        req_valid = 2'b11;
        out_ready = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (req_ready == 2'b00 && n < 20) begin
                @(negedge clk); #1; n++;
            end
            check("rr.grant", 32'(req_ready), (k % 2 == 0) ? 32'h1 : 32'h2);
            @(negedge clk); #1;
            check("rr.dec_ready", 32'(req_ready), 32'h0);
            @(negedge clk); #1;
            check("rr.out_ready", 32'(req_ready), 32'h0);
            check("rr.src", 32'(out_src), 32'(k % 2));
            @(negedge clk); #1;
        end
        req_valid = '0;

        // Directed decode vectors
        send(0, CW_A5,  "clean",  8'hA5, 4'd0,  1'b0, 1'b0);
        send(0, CW_LIT, "clean2", 8'h9A, 4'd0,  1'b0, 1'b0);
        send(1, CW_E6,  "err6",   8'hA5, 4'd6,  1'b1, 1'b0);
        send(1, CW_E8,  "par8",   8'hA5, 4'd8,  1'b1, 1'b0);
        send(0, CW_E12, "err12",  8'hA5, 4'd12, 1'b1, 1'b0);
        send(1, CW_S13, "bad13",  8'hA4, 4'd13, 1'b0, 1'b1);
        send(0, CW_S14, "bad14",  8'hA4, 4'd14, 1'b0, 1'b1);

        // Backpressure: 10 stalled cycles in OUT with both requesters pending
        @(negedge clk);
        req0_code = CW_E6;
        req_valid = 2'b01;
        out_ready = 1'b0;
        #1;
        @(negedge clk); #1;
        req_valid = 2'b11;
        @(negedge clk); #1;
        for (int i = 0; i < 10; i++) begin
            check("bp.valid", 32'(out_valid),    32'h1);
            check("bp.data",  32'(out_data),     32'hA5);
            check("bp.syn",   32'(out_syndrome), 32'h6);
            check("bp.src",   32'(out_src),      32'h0);
            check("bp.ready", 32'(req_ready),    32'h0);
            @(negedge clk); #1;
        end
        out_ready = 1'b1;
        @(negedge clk); #1;
        check("bp.drain", 32'(out_valid), 32'h0);
        check("bp.idle_grant", 32'(req_ready), 32'h2);
        req_valid = '0;

        // Reset asserted while in DEC: nothing emitted, outputs return to reset values
        @(negedge clk);
        req0_code = CW_E6;
        req_valid = 2'b01;
        #1;
        @(negedge clk);
        req_valid = '0;
        rst = 1'b1;
        #1;
        check_reset_vals("rst_dec");
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            check("rst_dec.no_out", 32'(out_valid), 32'h0);
        end
        req_valid = 2'b11;
        #1;
        check("rst_dec.last_grant", 32'(req_ready), 32'h1);
        req_valid = '0;

`ifdef HAMDEC_ERRCNT_EN
        check("cnt.start", 32'(err_count), 32'h0);
        send(0, CW_E6, "cnt1", 8'hA5, 4'd6, 1'b1, 1'b0);
        send(0, CW_A5, "cnt_clean", 8'hA5, 4'd0, 1'b0, 1'b0);
        send(1, CW_E8, "cnt2", 8'hA5, 4'd8, 1'b1, 1'b0);
        send(0, CW_S14, "cnt_bad", 8'hA4, 4'd14, 1'b0, 1'b1);
        send(1, CW_E12, "cnt3", 8'hA5, 4'd12, 1'b1, 1'b0);
        check("cnt.three", 32'(err_count), 32'h3);
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        #1;
        check("cnt.clear", 32'(err_count), 32'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
